fp_acc_seq: RTL and testbench
=============================

# fp_acc_seq

Sequential FP32 accumulation controller that sits directly around the combinational single-precision adder. It feeds the adder's `a`/`b` operands from a running-sum register and a captured input sample, and consumes the adder's `result` back into that register. It sums a programmed number of streamed samples through a valid/ready handshake. It also handles the zero, exact-cancellation and Inf/NaN cases that the combinational adder does not cover.

## Interface
Parameters:
- `CNT_W`, 8, width of the sample-count field and internal down-counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin an accumulation; sampled only in IDLE
- `len`  in  CNT_W  number of samples to sum; latched on accepted `start`
- `in_valid`  in  1  `in_data` holds a sample
- `in_ready`  out  1  block accepts a sample this cycle
- `in_data`  in  32  IEEE-754 single-precision sample
- `add_a`  out  32  adder operand a = running-sum register
- `add_b`  out  32  adder operand b = captured-sample register
- `add_result`  in  32  combinational adder output
- `busy`  out  1  high in ACCEPT and ADD
- `done`  out  1  one-cycle pulse; `sum` is valid
- `sum`  out  32  final sum; updated only on entry to DONE
- `exc`  out  1  sticky: an Inf/NaN sample was seen in the current run

## Operation
- States: IDLE, ACCEPT, ADD, DONE. Encoding is free.
- IDLE, `start`=1:
  - `len`→`remaining`, `acc`←0, `opnd`←0, `exc`←0.
  - Go to DONE if `len`==0, else go to ACCEPT.
- IDLE, `start`=0: stay. `start` in any other state is ignored.
- ACCEPT:
  - `in_ready`=1.
  - On `in_valid`: `opnd`←`in_data`, go to ADD. Otherwise stay.
- ADD: one cycle. `acc` is updated at the exiting edge. Priority order:
  1. `opnd[30:23]`==8'hFF: `exc`←1, `acc` unchanged (sample discarded).
  2. `opnd[30:23]`==0 (zero/denormal, flushed): `acc` unchanged.
  3. `acc[30:23]`==0: `acc`←`opnd`.
  4. `acc[30:0]`==`opnd[30:0]` and signs differ: `acc`←32'h0000_0000.
  5. Otherwise: `acc`←`add_result`.
- ADD exit, counter and next state:
  - `remaining`←`remaining`−1.
  - Go to DONE if the decremented value is 0, else go to ACCEPT.
- DONE:
  - `done`=1 and `sum` loads `acc` on the entering edge.
  - Next cycle go to IDLE.
- `add_a`=`acc` and `add_b`=`opnd`, driven straight from registers (no combinational path from `in_data`).
- `exc` and `sum` hold after DONE until the next accepted `start` (`exc`) or the next DONE (`sum`).

## Timing
- Reset (async assert, sync-safe deassert):
  - State becomes IDLE.
  - `in_ready`, `busy`, `done`, `exc` = 0.
  - `sum`, `add_a`, `add_b` = 32'h0.
  - `remaining` = 0.
- Reset mid-run: the in-flight sample and partial sum are discarded. No `done` is produced.
- Per-sample cost: one ACCEPT cycle (handshake) plus one ADD cycle. Maximum throughput is 1 sample per 2 cycles.
- Cycle timing, with `start` sampled in cycle 0 and `in_valid` held high:
  - Samples are accepted in cycles 1, 3, …, 2N−1.
  - `done` is high in cycle 2N+1.
  - `len`=0 gives `done` in cycle 1.
- Each cycle `in_valid` is low during ACCEPT delays `done` by exactly one cycle.
- `in_ready` is never high outside ACCEPT, so no sample is taken in IDLE, ADD or DONE.
- `len`=2^CNT_W−1 must complete correctly (no counter wrap). `remaining` never underflows.
- `done` and `busy` are never high in the same cycle.

## Test plan
- `len`=3; samples 3F800000, 40000000, 3F000000; `in_valid` always high.
  - `done` in cycle 7, `sum`=40600000 (3.5), `exc`=0.
- `len`=2; samples 00000000, 40400000 → `sum`=40400000.
- `len`=2; samples 3F800000, BF800000 → `sum`=00000000.
- `len`=2; samples 7F800000, 3F800000 → `sum`=3F800000, `exc`=1.
  - Follow with a new `start`, `len`=1, sample 40000000 → `exc` cleared, `sum`=40000000.
- Backpressure and ignored `start`:
  - `len`=3, same samples as the first case, `in_valid` low for 3 cycles before the second sample → `done` in cycle 10, `sum`=40600000.
  - `start` pulsed during ADD → ignored.
- Reset and zero-length runs:
  - `rst_n` low in the ADD cycle of sample 2 → all outputs 0 next cycle, no `done`.
  - `len`=0 → `done` in cycle 1, `sum`=00000000.

Source files
------------

// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sequential FP32 accumulation controller around a combinational adder.
// It sums `len` streamed single-precision samples into a running-sum register.
// The external combinational adder does not handle zero operands, exact
// cancellation or Inf/NaN, so this block covers those cases itself.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start, len   - begin a run of `len` samples (sampled only while idle)
//   in_valid     - input sample handshake: valid from the source
//   in_ready     - input sample handshake: ready from this block
//   in_data      - FP32 sample
//   add_a, add_b - adder operands (running sum, captured sample), both registered
//   add_result   - combinational adder result
//   busy         - a run is collecting or adding samples
//   done         - one-cycle pulse; `sum` holds the final result
//   sum          - final sum, updated only when a run completes
//   exc          - sticky flag: an Inf/NaN sample was discarded in this run
module fp_acc_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             exc
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_ADD    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              exc_q, exc_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand classification for the ADD step
  logic [EXP_W-1:0] opnd_exp;
  logic [EXP_W-1:0] acc_exp;
  logic             opnd_special;
  logic             opnd_zero;
  logic             acc_zero;
  logic             cancel;

  assign opnd_exp     = opnd_q[30:23];
  assign acc_exp      = acc_q[30:23];
  assign opnd_special = (opnd_exp == {EXP_W{1'b1}});
  assign opnd_zero    = (opnd_exp == '0);
  assign acc_zero     = (acc_exp == '0);
  assign cancel       = (acc_q[30:0] == opnd_q[30:0]) && (acc_q[31] != opnd_q[31]);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    exc_d   = exc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          opnd_d  = '0;
          exc_d   = 1'b0;
          state_d = (len == '0) ? ST_DONE : ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        if (in_valid) begin
          opnd_d  = in_data;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        // Special cases first; the adder only sees two normal, non-cancelling operands
        if (opnd_special) begin
          exc_d = 1'b1;
        end else if (opnd_zero) begin
          acc_d = acc_q;
        end else if (acc_zero) begin
          acc_d = opnd_q;
        end else if (cancel) begin
          acc_d = '0;
        end else begin
          acc_d = add_result;
        end

        // Saturating decrement: a zero count here can only follow a corrupted run
        if (rem_q <= CNT_W'(1)) begin
          rem_d   = '0;
          state_d = ST_DONE;
        end else begin
          rem_d   = rem_q - CNT_W'(1);
          state_d = ST_ACCEPT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result is captured on the edge that enters DONE
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      sum_d = acc_d;
    end

    in_ready_d = (state_d == ST_ACCEPT);
    busy_d     = (state_d == ST_ACCEPT) || (state_d == ST_ADD);
    done_d     = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      opnd_q     <= '0;
      sum_q      <= '0;
      rem_q      <= '0;
      exc_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      sum_q      <= sum_d;
      rem_q      <= rem_d;
      exc_q      <= exc_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign add_a    = acc_q;
  assign add_b    = opnd_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign exc      = exc_q;

endmodule

// File: tb/tb_fp_acc_seq.sv
// Testbench for fp_acc_seq: drives runs of FP32 samples, stands in for the
// combinational adder, and scoreboards sum, exc and completion cycle.
// Sample values are exact multiples of 2^-8 so sums stay exactly representable.
module tb_fp_acc_seq;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic             busy;
  logic             done;
  logic [31:0]      sum;
  logic             exc;

  fp_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .exc        (exc)
  );

  typedef struct {
    logic [31:0] sum;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scaled-integer view of an FP32 value (units of 2^-8); 0 when not exact
  function automatic bit fp_dec(input logic [31:0] f, output longint v);
    int          sh;
    logic [23:0] m;
    logic [23:0] lowmask;
    v  = 0;
    sh = int'(f[30:23]) - 119;
    if (f[30:23] == 8'h00 || f[30:23] == 8'hFF || sh < 0 || sh > 23) return 1'b0;
    m       = {1'b1, f[22:0]};
    lowmask = (24'(1) << (23 - sh)) - 24'(1);
    if ((m & lowmask) != 24'(0)) return 1'b0;
    v = longint'(m >> (23 - sh));
    if (f[31]) v = -v;
    return 1'b1;
  endfunction

  function automatic logic [31:0] fp_enc(input longint v);
    longint      mag;
    int          p;
    logic [23:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p   = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    m = 24'(mag << (23 - p));
    return {(v < 0), 8'(p + 119), m[22:0]};
  endfunction

  // Adder stand-in: exact for normal operands; poisons cases it is not meant to see
  function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b);
    longint va, vb, s;
    bit     oka, okb;
    oka = fp_dec(a, va);
    okb = fp_dec(b, vb);
    if (!oka || !okb) return 32'hDEAD_BEEF;
    s = va + vb;
    if (s == 0 || s >= 64'sd16777216 || s <= -64'sd16777216) return 32'hDEAD_BEEF;
    return fp_enc(s);
  endfunction

  always_comb add_result = stub_add(add_a, add_b);

  // Reference: real-valued sum of finite nonzero samples; Inf/NaN set the flag
  function automatic void ref_model(input logic [31:0] smp[$], output logic [31:0] s,
                                    output logic e);
    longint acc;
    longint v;
    bit     ok;
    acc = 0;
    e   = 1'b0;
    foreach (smp[i]) begin
      if (smp[i][30:23] == 8'hFF) e = 1'b1;
      else if (smp[i][30:23] != 8'h00) begin
        ok = fp_dec(smp[i], v);
        if (ok) acc += v;
      end
    end
    s = fp_enc(acc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_busy"},     32'(busy),     32'h0);
    chk({tag, "_done"},     32'(done),     32'h0);
    chk({tag, "_exc"},      32'(exc),      32'h0);
    chk({tag, "_sum"},      sum,           32'h0);
    chk({tag, "_add_a"},    add_a,         32'h0);
    chk({tag, "_add_b"},    add_b,         32'h0);
  endtask

  // Monitor: pop and compare whenever the DUT reports completion
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("FAIL done_busy_overlap act=1 exp=0 cyc=%0d", cyc);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done act=1 exp=0 cyc=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("exc", 32'(exc), 32'(e.exc));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // One run: starts at #1 after a posedge with the DUT idle; returns the same way
  task automatic run_seq(input logic [31:0] smp[$], input int gap[$], input bit poke_start,
                         input int abort_at, input int n);
    int   k;
    int   stalls;
    int   waitn;
    int   t;
    bit   hs;
    exp_t e;
    stalls = 0;
    for (int i = 0; i < n; i++) stalls += gap[i];
    start    = 1'b1;
    len      = CNT_W'(n);
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k     = cyc;
    if (abort_at < 0) begin
      ref_model(smp, e.sum, e.exc);
      e.cyc = k + 2 * n + stalls;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      waitn    = ((i == 0) ? 0 : 1) + gap[i];
      for (int w = 0; w < waitn; w++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = smp[i];
      hs = 1'b0;
      for (t = 0; t < 50 && !hs; t++) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
      end
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL handshake_timeout act=0 exp=1 sample=%0d", i);
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      if (poke_start && i == 0) begin
        start = 1'b1;
        len   = CNT_W'(5);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout act=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int          g[$];
    logic [31:0] sp[6];
    logic [31:0] x;
    longint      run;
    longint      v;
    bit          ok;
    int          n;

    sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0123, 32'h8000_0000, 32'h0};
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; g = '{0, 0, 0};
    run_seq(q, g, 1'b0, -1, 3);
    chk("direct_sum_3p5", sum, 32'h4060_0000);
    q = '{32'h0000_0000, 32'h4040_0000}; g = '{0, 0};
    run_seq(q, g, 1'b0, -1, 2);
    q = '{32'h3F80_0000, 32'hBF80_0000}; g = '{0, 0};
    run_seq(q, g, 1'b0, -1, 2);
    q = '{32'h7F80_0000, 32'h3F80_0000}; g = '{0, 0};
    run_seq(q, g, 1'b0, -1, 2);
    q = '{32'h4000_0000}; g = '{0};
    run_seq(q, g, 1'b0, -1, 1);
    q = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; g = '{0, 3, 0};
    run_seq(q, g, 1'b0, -1, 3);
    g = '{0, 0, 0};
    run_seq(q, g, 1'b1, -1, 3);
    run_seq(q, g, 1'b0, 1, 3);
    q.delete(); g.delete();
    run_seq(q, g, 1'b0, -1, 0);

    q.delete(); g.delete();
    for (int i = 0; i < 255; i++) begin
      v = longint'($urandom_range(1, 32767));
      if ($urandom_range(0, 1) == 1) v = -v;
      q.push_back(fp_enc(v));
      g.push_back(0);
    end
    run_seq(q, g, 1'b0, -1, 255);

    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(1, 20));
      run = 0;
      q.delete(); g.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0: x = sp[$urandom_range(0, 5)];
          1: x = (run != 0) ? fp_enc(-run) : sp[4];
          default: begin
            v = longint'($urandom_range(1, 32767));
            if ($urandom_range(0, 1) == 1) v = -v;
            x = fp_enc(v);
          end
        endcase
        if (x[30:23] != 8'hFF && x[30:23] != 8'h00) begin
          ok = fp_dec(x, v);
          if (ok) run += v;
        end
        q.push_back(x);
        g.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_seq(q, g, ($urandom_range(0, 3) == 0) && (n >= 2), -1, n);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
